mmap_read_streamer: RTL and testbench

//  Converts one (base address, beam count) command into a run of per-beam read addresses pushed into the

---
 rtl/mmap_read_streamer.sv | 124 ++++++++++++
 tb/tb_mmap_read_streamer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmap_read_streamer.sv
// Read-channel front end for async_mmap: expands a (base, len) command into per-beam addresses
// and forwards the returned beams as a stream with a last flag, capping in-flight beams.
module mmap_read_streamer #(
    parameter int unsigned AddrWidth         = 64,
    parameter int unsigned DataWidth         = 512,
    parameter int unsigned DataWidthBytesLog = 6,
    parameter int unsigned CountWidth        = 32,
    parameter int unsigned MaxOutstanding    = 32,
    parameter int unsigned OutstandingLog    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AddrWidth-1:0]  cmd_addr_din,
    input  logic [CountWidth-1:0] cmd_len_din,
    input  logic                  cmd_write,
    output logic                  cmd_full_n,
    output logic [AddrWidth-1:0]  read_addr_din,
    output logic                  read_addr_write,
    input  logic                  read_addr_full_n,
    input  logic [DataWidth-1:0]  read_data_dout,
    output logic                  read_data_read,
    input  logic                  read_data_empty_n,
    output logic [DataWidth-1:0]  out_din,
    output logic                  out_last,
    output logic                  out_write,
    input  logic                  out_full_n,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [OutstandingLog-1:0] MaxOut = OutstandingLog'(MaxOutstanding);

    state_e                    state_q, state_d;
    logic [AddrWidth-1:0]      base_q, base_d;
    logic [CountWidth-1:0]     len_q, len_d;
    logic [CountWidth-1:0]     issued_q, issued_d;
    logic [CountWidth-1:0]     received_q, received_d;
    logic [OutstandingLog-1:0] outstanding_q, outstanding_d;

    logic cmd_accept, issue, xfer, last_beam;

    always_comb begin
        cmd_accept = (state_q == StIdle) && cmd_write;
        issue      = (state_q == StRun) && (issued_q < len_q) && (outstanding_q < MaxOut)
                     && read_addr_full_n;
        // Only pop beams we actually asked for; strays while outstanding==0 stay in the FIFO.
        xfer       = (state_q == StRun) && (outstanding_q != '0) && read_data_empty_n
                     && out_full_n;
        last_beam  = xfer && (received_q == len_q - CountWidth'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) state_d = (cmd_len_din == '0) ? StDone : StRun;
            end
            StRun: begin
                if (last_beam) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_full_n      = (state_q == StIdle);
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        read_addr_write = issue;
        read_addr_din   = base_q + (AddrWidth'(issued_q) << DataWidthBytesLog);
        read_data_read  = xfer;
        out_write       = xfer;
        out_last        = last_beam;
        out_din         = read_data_dout;
    end

    always_comb begin
        base_d        = base_q;
        len_d         = len_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;
        if (cmd_accept) begin
            base_d        = cmd_addr_din;
            len_d         = cmd_len_din;
            issued_d      = '0;
            received_d    = '0;
            outstanding_d = '0;
        end else begin
            if (issue) issued_d = issued_q + CountWidth'(1);
            if (xfer) received_d = received_q + CountWidth'(1);
            if (issue && !xfer) outstanding_d = outstanding_q + OutstandingLog'(1);
            if (!issue && xfer) outstanding_d = outstanding_q - OutstandingLog'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
        end else begin
            base_q        <= base_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_mmap_read_streamer.sv
// Scoreboard bench for mmap_read_streamer with a small async_mmap stand-in on the read channel.
module tb_mmap_read_streamer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  cmd_addr_din;
    logic [31:0]  cmd_len_din;
    logic         cmd_write;
    logic         cmd_full_n;
    logic [63:0]  read_addr_din;
    logic         read_addr_write;
    logic         read_addr_full_n;
    logic [511:0] read_data_dout;
    logic         read_data_read;
    logic         read_data_empty_n;
    logic [511:0] out_din;
    logic         out_last;
    logic         out_write;
    logic         out_full_n;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    mmap_read_streamer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_addr_din      (cmd_addr_din),
        .cmd_len_din       (cmd_len_din),
        .cmd_write         (cmd_write),
        .cmd_full_n        (cmd_full_n),
        .read_addr_din     (read_addr_din),
        .read_addr_write   (read_addr_write),
        .read_addr_full_n  (read_addr_full_n),
        .read_data_dout    (read_data_dout),
        .read_data_read    (read_data_read),
        .read_data_empty_n (read_data_empty_n),
        .out_din           (out_din),
        .out_last          (out_last),
        .out_write         (out_write),
        .out_full_n        (out_full_n),
        .done              (done),
        .busy              (busy)
    );

    function automatic logic [511:0] beam_of(input logic [63:0] a);
        return {8{a ^ 64'hC3C3_5A5A_0F0F_9696}};
    endfunction

    // async_mmap stand-in: addresses pushed become beams one cycle later, in order.
    logic [63:0] mem [0:255];
    logic [7:0]  wr_ptr, rd_ptr;
    logic        hold_data;

    always @(posedge clk) begin
        if (read_addr_write) mem[wr_ptr] <= read_addr_din;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 8'd0;
            rd_ptr <= 8'd0;
        end else begin
            if (read_addr_write) wr_ptr <= wr_ptr + 8'd1;
            if (read_data_read) rd_ptr <= rd_ptr + 8'd1;
        end
    end

    assign read_data_empty_n = (wr_ptr != rd_ptr) && !hold_data;
    assign read_data_dout    = beam_of(mem[rd_ptr]);

    int n_tests = 0;
    int n_fail  = 0;
    int addr_pushes = 0;
    int beats = 0;
    int done_cnt = 0;
    int outst = 0;
    logic bound_err = 1'b0;
    logic [63:0]  exp_addr [$];
    logic [512:0] exp_beam [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pushes an address or a stream beam.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr.delete();
            exp_beam.delete();
            outst = 0;
        end else begin
            if (read_addr_write) begin
                addr_pushes++;
                n_tests++;
                if (!read_addr_full_n) begin
                    n_fail++;
                    $display("FAIL addr_push_while_full: write=1 full_n=0 expected no push");
                end
                n_tests++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL addr_unexpected: got %h expected none", read_addr_din);
                end else begin
                    logic [63:0] ea;
                    ea = exp_addr.pop_front();
                    if (read_addr_din !== ea) begin
                        n_fail++;
                        $display("FAIL addr: got %h expected %h", read_addr_din, ea);
                    end
                end
            end
            outst = outst + int'(read_addr_write) - int'(read_data_read);
            if (outst > 32 || outst < 0) bound_err = 1'b1;
            if (out_write) begin
                beats++;
                n_tests++;
                if (exp_beam.size() == 0) begin
                    n_fail++;
                    $display("FAIL beam_unexpected: got %h expected none", out_din[63:0]);
                end else begin
                    logic [512:0] eb;
                    eb = exp_beam.pop_front();
                    if ({out_last, out_din} !== eb || read_data_read !== 1'b1) begin
                        n_fail++;
                        $display("FAIL beam: got last=%b pop=%b data=%h expected last=%b data=%h",
                                 out_last, read_data_read, out_din[63:0], eb[512], eb[63:0]);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_beam(input logic [63:0] a, input logic last);
        exp_addr.push_back(a);
        exp_beam.push_back({last, beam_of(a)});
    endtask

    task automatic expect_run(input logic [63:0] base, input int len);
        for (int i = 0; i < len; i++) push_beam(base + (64'(i) << 6), i == len - 1);
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] len);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        while (!cmd_full_n && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_ready", {63'd0, cmd_full_n}, 64'd1);
        cmd_addr_din = a;
        cmd_len_din  = len;
        cmd_write    = 1'b1;
        @(posedge clk);
        #1;
        cmd_write = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_count"}, 64'(done_cnt), 64'(target));
        chk({name, "_addr_q_empty"}, 64'(exp_addr.size()), 64'd0);
        chk({name, "_beam_q_empty"}, 64'(exp_beam.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_cmd_full_n"}, {63'd0, cmd_full_n}, 64'd1);
        chk({name, "_read_addr_write"}, {63'd0, read_addr_write}, 64'd0);
        chk({name, "_read_data_read"}, {63'd0, read_data_read}, 64'd0);
        chk({name, "_out_write"}, {63'd0, out_write}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int a0, b0, d0, t;
        rst_n            = 1'b0;
        cmd_addr_din     = '0;
        cmd_len_din      = '0;
        cmd_write        = 1'b0;
        read_addr_full_n = 1'b1;
        out_full_n       = 1'b1;
        hold_data        = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: four beams from 0x1000, 64-byte stride
        push_beam(64'h1000, 1'b0);
        push_beam(64'h1040, 1'b0);
        push_beam(64'h1080, 1'b0);
        push_beam(64'h10C0, 1'b1);
        b0 = beats;
        send_cmd(64'h1000, 32'd4);
        wait_done("t1", 1);
        chk("t1_beats", 64'(beats - b0), 64'd4);

        // 2: zero-length run goes straight to DONE
        a0 = addr_pushes;
        b0 = beats;
        send_cmd(64'h5000, 32'd0);
        chk("t2_done_next_cycle", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        chk("t2_done_one_cycle", {63'd0, done}, 64'd0);
        chk("t2_cmd_full_n", {63'd0, cmd_full_n}, 64'd1);
        wait_done("t2", 2);
        chk("t2_no_addr", 64'(addr_pushes - a0), 64'd0);
        chk("t2_no_beats", 64'(beats - b0), 64'd0);

        // 3: data withheld, issue must stall at the outstanding cap
        hold_data = 1'b1;
        a0 = addr_pushes;
        b0 = beats;
        expect_run(64'h2_0000, 100);
        send_cmd(64'h2_0000, 32'd100);
        repeat (60) @(posedge clk);
        #1;
        chk("t3_capped_issue", 64'(addr_pushes - a0), 64'd32);
        hold_data = 1'b0;
        wait_done("t3", 3);
        chk("t3_beats", 64'(beats - b0), 64'd100);

        // 4: random stream backpressure and a 10-cycle address-FIFO stall
        b0 = beats;
        expect_run(64'h4_0000, 40);
        send_cmd(64'h4_0000, 32'd40);
        t = 0;
        while (done_cnt < 4 && t < 2000) begin
            out_full_n       = 1'($urandom_range(0, 1));
            read_addr_full_n = !(t >= 2 && t < 12);
            @(posedge clk);
            #1;
            t++;
        end
        out_full_n       = 1'b1;
        read_addr_full_n = 1'b1;
        wait_done("t4", 4);
        chk("t4_beats", 64'(beats - b0), 64'd40);

        // 5: address wraps past 2^64
        push_beam(64'hFFFF_FFFF_FFFF_FFC0, 1'b0);
        push_beam(64'h0000_0000_0000_0000, 1'b1);
        send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        wait_done("t5", 5);

        // 6: reset part-way through a ten-beam run, then a clean run
        b0 = beats;
        d0 = done_cnt;
        expect_run(64'h6_0000, 10);
        send_cmd(64'h6_0000, 32'd10);
        t = 0;
        while (beats - b0 < 5 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t6_reached_five", {63'd0, (beats - b0 >= 5)}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("t6_no_done_on_abort", 64'(done_cnt), 64'(d0));
        b0 = beats;
        expect_run(64'h7_0000, 3);
        send_cmd(64'h7_0000, 32'd3);
        wait_done("t6", d0 + 1);
        chk("t6_beats", 64'(beats - b0), 64'd3);

        chk("outstanding_bounds", {63'd0, bound_err}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
